fact_game_ctrl: RTL
===================

// Module: fact_game_ctrl
// PURPOSE
//  Round controller for the 2-player factor game. Produces STATE/QUE/DIN codes for the 7-seg decoders.
//  Flow per round: show a digit (QUE), open a timed answer window (DIN gauge 0..9), judge the first press, score.
//  Shared codes: READY=0010 QUESTION=0011 INPUT=0100 DRAW=0110 WRONG=0111 GOOD=1000 OUCH=1001 WIN=1010 LOSE=1011.
// PARAMETERS
//  TICK_DIV      5_000_000  CLK cycles per game tick (0.1 s at 50 MHz); >=2
//  QUE_TICKS     10         ticks QUESTION is held
//  RESULT_TICKS  20         ticks GOOD/OUCH/WRONG/DRAW is held
//  WIN_SCORE     3          score ending the match; 1..9
// PORTS
//  CLK      in   1  system clock
//  RST      in   1  synchronous, active-high reset
//  START    in   1  1-cycle pulse: begin match (READY) / restart (WIN, LOSE)
//  KEY_A    in   1  player A button, debounced, synchronous level
//  KEY_B    in   1  player B button, debounced, synchronous level
//  STATE    out  4  current state code (table above)
//  QUE      out  4  question digit 0..9
//  DIN      out  4  answer-window gauge 0..9
//  SCORE_A  out  4  player A score 0..WIN_SCORE
//  SCORE_B  out  4  player B score 0..WIN_SCORE
// BEHAVIOUR
//  Reset: STATE=READY, QUE=0, DIN=0, SCORE_A=SCORE_B=0, tick counter=0, rnd=0, key history=0.
//  RST mid-round: same values on the next edge; nothing else carries over.
//  Tick: prescaler restarts at 0 on every STATE change; tick pulses when count==TICK_DIV-1. Durations are exact.
//  rnd: free-running mod-10 counter, +1 every CLK, 9 wraps to 0.
//  Press: rising edge only (KEY & ~KEY_q). Edges outside INPUT are ignored, but history keeps updating.
//  Holding a key across INPUT entry is not a press.
//  READY: START -> QUESTION next cycle; QUE<=rnd; DIN<=0.
//  QUESTION: after QUE_TICKS ticks -> INPUT; DIN<=0.
//  INPUT: DIN+1 per tick. Evaluate in priority order:
//   1. Edge A and B in same cycle -> DRAW, no score.
//   2. Single edge, QUE composite (4,6,8,9) -> GOOD, presser +1.
//   3. Single edge, QUE in {0,1,2,3,5,7} -> OUCH, opponent +1.
//   4. Tick with DIN==9, no edge: composite -> WRONG; otherwise -> DRAW; no score.
//  A press in the same cycle as the timeout tick wins over the timeout.
//  Result is registered: STATE changes on the edge that first samples KEY high.
//  GOOD/OUCH/WRONG/DRAW: after RESULT_TICKS ticks:
//   SCORE_A==WIN_SCORE -> WIN; SCORE_B==WIN_SCORE -> LOSE; else QUESTION with a new QUE<=rnd.
//  Scores saturate at WIN_SCORE. Only one score changes per round, so WIN and LOSE never tie.
//  WIN/LOSE: held indefinitely. START -> READY, scores cleared.
//  START outside READ/WIN/LOSE: ignored.
//  DIN and QUE hold their values outside INPUT/QUESTION. Unused STATE codes are never driven.
// STRUCTURE
//  Shared package fact_game_pkg: 4-bit state-code localparams, composite-digit function.
//   The 7-seg decoders use the same package.
//  Sub-module game_tick_gen (TICK_DIV): counter + clear input, tick pulse out.
//  Top: rnd counter, key edge detect, state register, round tick counter, score registers.
// TESTING (sim TICK_DIV=4, QUE_TICKS=2, RESULT_TICKS=2, WIN_SCORE=2)
//  Reset: RST held 3 cycles -> STATE=0010, QUE=0, DIN=0, scores 0; START during RST ignored.
//  Good answer: START when rnd=6 -> QUE=6, QUESTION 8 cycles, INPUT.
//   KEY_A rises at DIN=3 -> STATE=1000 next edge, SCORE_A=1.
//  Wrong claim: QUE=7, KEY_B edge -> STATE=1001, SCORE_A+1; simultaneous A/B edges -> 0110, scores unchanged.
//  Timeout: QUE=9, no keys -> DIN 0..9 then 0111 after 40 INPUT cycles.
//   QUE=5, no keys -> 0110. Key edge on the timeout cycle -> judged press.
//  Match end: SCORE_A reaches 2 -> 1010 after result hold; held 100 cycles; START -> 0010, scores 0.
//   Mirror case for B -> 1011.
//  Mid-round reset: RST in INPUT at DIN=5 -> READY/zeros next edge.
//   Key held high through QUESTION->INPUT -> no press registered.

Source files
------------

// File: rtl/fact_game_pkg.sv
// Purpose  : shared state codes and digit helpers for the factor game and its 7-seg decoders.
// Latency  : n/a (constants and pure functions only).
// Backpres.: n/a.
package fact_game_pkg;

  localparam logic [3:0] CODE_READY    = 4'b0010;
  localparam logic [3:0] CODE_QUESTION = 4'b0011;
  localparam logic [3:0] CODE_INPUT    = 4'b0100;
  localparam logic [3:0] CODE_DRAW     = 4'b0110;
  localparam logic [3:0] CODE_WRONG    = 4'b0111;
  localparam logic [3:0] CODE_GOOD     = 4'b1000;
  localparam logic [3:0] CODE_OUCH     = 4'b1001;
  localparam logic [3:0] CODE_WIN      = 4'b1010;
  localparam logic [3:0] CODE_LOSE     = 4'b1011;

  // The enum encoding equals the display code, so STATE is the register itself.
  typedef enum logic [3:0] {
    ST_READY    = CODE_READY,
    ST_QUESTION = CODE_QUESTION,
    ST_INPUT    = CODE_INPUT,
    ST_DRAW     = CODE_DRAW,
    ST_WRONG    = CODE_WRONG,
    ST_GOOD     = CODE_GOOD,
    ST_OUCH     = CODE_OUCH,
    ST_WIN      = CODE_WIN,
    ST_LOSE     = CODE_LOSE
  } state_e;

  // Composite digits in 0..9 are 4, 6, 8 and 9.
  function automatic logic is_composite(input logic [3:0] d);
    return (d == 4'd4) || (d == 4'd6) || (d == 4'd8) || (d == 4'd9);
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Purpose  : game-tick prescaler; one-cycle tick every TICK_DIV clocks, restartable.
// Latency  : tick asserts while count == TICK_DIV-1; clr takes effect on the next edge.
// Backpres.: none; clr simply restarts the count at 0.
// Ports    : clk, rst (sync, active-high), clr (restart count), tick (pulse out).
module game_tick_gen #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/fact_game_ctrl.sv
// Purpose  : round controller for the 2-player factor game; drives STATE/QUE/DIN/score codes.
// Latency  : a key rising edge changes STATE and score on the edge that first samples it high.
// Backpres.: none; presses outside the answer window are dropped, START honoured only in READY/WIN/LOSE.
// Ports    : CLK, RST (sync, active-high), START pulse, KEY_A/KEY_B levels,
//            STATE/QUE/DIN/SCORE_A/SCORE_B 4-bit display codes.
module fact_game_ctrl
  import fact_game_pkg::*;
#(
  parameter int TICK_DIV     = 5_000_000,
  parameter int QUE_TICKS    = 10,
  parameter int RESULT_TICKS = 20,
  parameter int WIN_SCORE    = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       KEY_A,
  input  logic       KEY_B,
  output logic [3:0] STATE,
  output logic [3:0] QUE,
  output logic [3:0] DIN,
  output logic [3:0] SCORE_A,
  output logic [3:0] SCORE_B
);

  localparam int RT_MAX = (QUE_TICKS > RESULT_TICKS) ? QUE_TICKS : RESULT_TICKS;
  localparam int RT_W   = $clog2(RT_MAX + 1);
  localparam logic [RT_W-1:0] QUE_LAST = RT_W'(QUE_TICKS - 1);
  localparam logic [RT_W-1:0] RES_LAST = RT_W'(RESULT_TICKS - 1);
  localparam logic [3:0]      WIN_VAL  = 4'(WIN_SCORE);

  state_e          state_q, state_d;
  logic [3:0]      que_q, que_d, din_q, din_d;
  logic [3:0]      score_a_q, score_a_d, score_b_q, score_b_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [RT_W-1:0] rtick_q, rtick_d;
  logic            key_a_q, key_b_q;
  logic            press_a, press_b, tick, state_chg;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s == WIN_VAL) ? s : s + 4'd1;
  endfunction

  // History updates in every state, so a key already high when INPUT opens is not an edge.
  assign press_a   = KEY_A & ~key_a_q;
  assign press_b   = KEY_B & ~key_b_q;
  assign state_chg = (state_d != state_q);

  // Prescaler restarts with each state so every hold is an exact multiple of TICK_DIV.
  game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (CLK),
    .rst  (RST),
    .clr  (state_chg),
    .tick (tick)
  );

  always_comb begin
    rnd_d = (rnd_q == 4'd9) ? 4'd0 : rnd_q + 4'd1;
  end

  always_comb begin
    state_d   = state_q;
    que_d     = que_q;
    din_d     = din_q;
    score_a_d = score_a_q;
    score_b_d = score_b_q;
    case (state_q)
      ST_READY: begin
        if (START) begin
          state_d = ST_QUESTION;
          que_d   = rnd_q;
          din_d   = 4'd0;
        end
      end
      ST_QUESTION: begin
        if (tick && (rtick_q == QUE_LAST)) begin
          state_d = ST_INPUT;
          din_d   = 4'd0;
        end
      end
      ST_INPUT: begin
        // Presses outrank the timeout tick; DIN freezes when the window closes.
        if (press_a && press_b) begin
          state_d = ST_DRAW;
        end else if (press_a || press_b) begin
          if (is_composite(que_q)) begin
            state_d = ST_GOOD;
            if (press_a) score_a_d = sat_inc(score_a_q);
            else         score_b_d = sat_inc(score_b_q);
          end else begin
            state_d = ST_OUCH;
            if (press_a) score_b_d = sat_inc(score_b_q);
            else         score_a_d = sat_inc(score_a_q);
          end
        end else if (tick) begin
          if (din_q == 4'd9) state_d = is_composite(que_q) ? ST_WRONG : ST_DRAW;
          else               din_d   = din_q + 4'd1;
        end
      end
      ST_DRAW, ST_WRONG, ST_GOOD, ST_OUCH: begin
        if (tick && (rtick_q == RES_LAST)) begin
          if (score_a_q == WIN_VAL)      state_d = ST_WIN;
          else if (score_b_q == WIN_VAL) state_d = ST_LOSE;
          else begin
            state_d = ST_QUESTION;
            que_d   = rnd_q;
          end
        end
      end
      ST_WIN, ST_LOSE: begin
        if (START) begin
          state_d   = ST_READY;
          score_a_d = 4'd0;
          score_b_d = 4'd0;
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  // Counts game ticks within the current state; only QUESTION and result holds use it.
  always_comb begin
    rtick_d = rtick_q;
    if (state_chg)  rtick_d = '0;
    else if (tick)  rtick_d = rtick_q + RT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_READY;
      que_q     <= 4'd0;
      din_q     <= 4'd0;
      score_a_q <= 4'd0;
      score_b_q <= 4'd0;
      rnd_q     <= 4'd0;
      rtick_q   <= '0;
      key_a_q   <= 1'b0;
      key_b_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      que_q     <= que_d;
      din_q     <= din_d;
      score_a_q <= score_a_d;
      score_b_q <= score_b_d;
      rnd_q     <= rnd_d;
      rtick_q   <= rtick_d;
      key_a_q   <= KEY_A;
      key_b_q   <= KEY_B;
    end
  end

  assign STATE   = state_q;
  assign QUE     = que_q;
  assign DIN     = din_q;
  assign SCORE_A = score_a_q;
  assign SCORE_B = score_b_q;

endmodule
